// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue -- instruction queue sitting between fetch and decode.
//
// A DEPTH-entry circular buffer of {pc, instr} pairs. Flush either empties
// the queue or, with keep_ds_i, keeps only the oldest entry (the branch
// delay slot). Head outputs read as zero (a NOP at PC 0) whenever the head
// is not valid.
//
// Optional feature macro: INST_QUEUE_BYPASS_EN
//   When defined, a push into an empty queue is forwarded combinationally
//   to the head outputs. If decode takes it in the same cycle it is never
//   written. Without the macro, pop_valid_o is derived only from registered
//   state, so there is a minimum latency of one cycle.
// ---------------------------------------------------------------------------
module inst_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       keep_ds_i,
   input  logic                       push_valid_i,
   input  logic [31:0]                push_pc_i,
   input  logic [31:0]                push_instr_i,
   output logic                       push_ready_o,
   input  logic                       pop_ready_i,
   output logic                       pop_valid_o,
   output logic [31:0]                pop_pc_o,
   output logic [31:0]                pop_instr_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      EMPTY,
      PARTIAL,
      FULL
   } state_t;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];

   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW-1:0] rd_ptr_nxt, wr_ptr_nxt;
   logic [CW-1:0] count, count_nxt;
   state_t        state;
   logic          bypass;
   logic          wr_en;
   logic          do_push;
   logic          do_pop;

   assign count_o = count;

   // Occupancy state, derived from the count register.
   always_comb begin
      if (count == '0)
         state = EMPTY;
      else if (count == CW'(DEPTH))
         state = FULL;
      else
         state = PARTIAL;
   end

   // Ready ignores pop_ready_i: a full queue refuses a push even while popping.
   assign push_ready_o = (state != FULL);

`ifdef INST_QUEUE_BYPASS_EN
   assign bypass = (state == EMPTY) && push_valid_i && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   // Head outputs: forwarded push, stored head, or zeros when nothing is valid.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      pop_valid_o = (state != EMPTY) || bypass;
      pop_pc_o    = 32'h0;
      pop_instr_o = 32'h0;
      if (bypass) begin
         pop_pc_o    = push_pc_i;
         pop_instr_o = push_instr_i;
      end else if (state != EMPTY) begin
         pop_pc_o    = pc_mem[rd_ptr];
         pop_instr_o = instr_mem[rd_ptr];
      end
   end

   // Next pointers and count. Flush takes priority over push and pop.
   always_comb begin
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      count_nxt  = count;
      wr_en      = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      if (flush_i) begin
         if (!keep_ds_i) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
         end else if (state != EMPTY) begin
            // Keep the head only. A same-cycle pop does not count, so the
            // retained head is presented again.
            wr_ptr_nxt = rd_ptr + PW'(1);
            count_nxt  = CW'(1);
         end else if (push_valid_i) begin
            // Empty queue: the incoming push becomes the retained delay slot.
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            count_nxt  = CW'(1);
         end
      end else begin
         // A bypassed push that decode takes at once is never stored.
         do_push = push_valid_i && push_ready_o && !(bypass && pop_ready_i);
         do_pop  = (state != EMPTY) && pop_ready_i;
         wr_en   = do_push;
         if (do_push)
            wr_ptr_nxt = wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr_nxt = rd_ptr + PW'(1);
         count_nxt = count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Pointer and count registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register updates from values sampled before the edge.
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= wr_ptr_nxt;
         count  <= count_nxt;
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset. count gates every read, so stale data
      // is never visible, and leaving it unreset keeps it a plain RAM.
      if (wr_en) begin
         pc_mem[wr_ptr]    <= push_pc_i;
         instr_mem[wr_ptr] <= push_instr_i;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue -- self-checking bench for inst_queue (DEPTH = 4).
// Reference model: a queue of {pc, instr} entries updated from the
// behavioural rules each cycle. Directed scenarios are followed by
// randomized traffic.
// ---------------------------------------------------------------------------
module tb_inst_queue;

   localparam int DEPTH = 4;
`ifdef INST_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i, keep_ds_i, push_valid_i, pop_ready_i;
   logic [31:0] push_pc_i, push_instr_i;
   logic        push_ready_o, pop_valid_o;
   logic [31:0] pop_pc_o, pop_instr_o;
   logic [2:0]  count_o;

   entry_t      q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] pc_seq;
   logic [31:0] saved_pc;

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .keep_ds_i    (keep_ds_i),
      .push_valid_i (push_valid_i),
      .push_pc_i    (push_pc_i),
      .push_instr_i (push_instr_i),
      .push_ready_o (push_ready_o),
      .pop_ready_i  (pop_ready_i),
      .pop_valid_o  (pop_valid_o),
      .pop_pc_o     (pop_pc_o),
      .pop_instr_o  (pop_instr_o),
      .count_o      (count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      flush_i      = 1'b0;
      keep_ds_i    = 1'b0;
      push_valid_i = 1'b0;
      push_pc_i    = 32'h0;
      push_instr_i = 32'h0;
      pop_ready_i  = 1'b0;
   endtask

   // One cycle: drive at the falling edge, check outputs against the model,
   // advance the model, then let the rising edge update the DUT.
   task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic pr, input logic fl, input logic kd);
      int          n;
      logic        rdy, byp, vld;
      logic [31:0] epc, ein;
      entry_t      e;
      push_valid_i = pv;
      push_pc_i    = pc;
      push_instr_i = ins;
      pop_ready_i  = pr;
      flush_i      = fl;
      keep_ds_i    = kd;
      #1;
      n   = q.size();
      rdy = (n < DEPTH);
      byp = BYP && (n == 0) && pv && !fl;
      vld = (n > 0) || byp;
      epc = 32'h0;
      ein = 32'h0;
      if (byp) begin
         epc = pc;
         ein = ins;
      end else if (n > 0) begin
         epc = q[0].pc;
         ein = q[0].instr;
      end
      check("count",      32'(count_o),      32'(n));
      check("push_ready", 32'(push_ready_o), 32'(rdy));
      check("pop_valid",  32'(pop_valid_o),  32'(vld));
      check("pop_pc",     pop_pc_o,          epc);
      check("pop_instr",  pop_instr_o,       ein);
      e.pc    = pc;
      e.instr = ins;
      if (fl) begin
         if (!kd) begin
            q.delete();
         end else if (n > 0) begin
            entry_t h;
            h = q[0];
            q.delete();
            q.push_back(h);
         end else if (pv) begin
            q.push_back(e);
         end
      end else if (byp && pr) begin
         // forwarded and consumed in the same cycle; nothing is stored
      end else begin
         if (pr && n > 0) void'(q.pop_front());
         if (pv && rdy)   q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check("rst_count",      32'(count_o),      32'd0);
      check("rst_pop_valid",  32'(pop_valid_o),  32'd0);
      check("rst_pop_pc",     pop_pc_o,          32'h0);
      check("rst_pop_instr",  pop_instr_o,       32'h0);
      check("rst_push_ready", 32'(push_ready_o), 32'd1);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      pulse_reset();

      // Fill to full with pop held off; the fifth push is rejected.
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      #1;
      check("full_count", 32'(count_o),      32'd4);
      check("full_ready", 32'(push_ready_o), 32'd0);
      step(1'b1, 32'hBFC0_0010, 32'h1000_0004, 1'b0, 1'b0, 1'b0);
      #1;
      check("reject_count", 32'(count_o), 32'd4);

      // Full queue: push and pop together -> only the pop happens.
      #1;
      check("full_head_pc", pop_pc_o, 32'hBFC0_0000);
      step(1'b1, 32'hBFC0_0010, 32'h1000_0004, 1'b1, 1'b0, 1'b0);
      #1;
      check("full_pop_count", 32'(count_o),  32'd3);
      check("full_pop_head",  pop_pc_o,      32'hBFC0_0004);

      // Streaming push and pop across the pointer wrap.
      pc_seq = 32'hBFC0_0010;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, pc_seq, $urandom, 1'b1, 1'b0, 1'b0);
         pc_seq += 32'd4;
      end

      // count=3, flush keeping the delay slot, pop requested.
      #1;
      saved_pc = pop_pc_o;
      check("ds_pre_count", 32'(count_o), 32'd3);
      step(1'b1, 32'hDEAD_0000, 32'h0, 1'b1, 1'b1, 1'b1);
      #1;
      check("ds_count", 32'(count_o), 32'd1);
      check("ds_head",  pop_pc_o,     saved_pc);

      // count=2, full flush with a push present.
      step(1'b1, pc_seq, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
      pc_seq += 32'd4;
      #1;
      check("fl_pre_count", 32'(count_o), 32'd2);
      step(1'b1, pc_seq, 32'hAAAA_0002, 1'b1, 1'b1, 1'b0);
      #1;
      check("fl_count", 32'(count_o),     32'd0);
      check("fl_instr", pop_instr_o,      32'h0);

      // Keep-delay-slot flush on an empty queue accepts the push.
      step(1'b1, 32'h8000_0180, 32'h0000_000C, 1'b0, 1'b1, 1'b1);
      #1;
      check("ds_empty_count", 32'(count_o), 32'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Reset mid-operation with count=3, then the first push afterwards.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'hBFC0_0100 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
      pulse_reset();
      push_valid_i = 1'b1;
      push_pc_i    = 32'hBFC0_0000;
      push_instr_i = 32'h2402_0001;
      #1;
      check("first_push_same_cycle", 32'(pop_valid_o), 32'(BYP));
      step(1'b1, 32'hBFC0_0000, 32'h2402_0001, 1'b0, 1'b0, 1'b0);
      #1;
      check("first_push_valid", 32'(pop_valid_o), 32'd1);
      check("first_push_instr", pop_instr_o,      32'h2402_0001);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         logic fl;
         fl = ($urandom_range(0, 15) == 0);
         step(($urandom_range(0, 9) < 7), pc_seq, $urandom,
              $urandom_range(0, 1) == 1, fl, $urandom_range(0, 1) == 1);
         pc_seq += 32'd4;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush_i  input  1  discard queued instructions (branch redirect/exception).
REQ-005 SHALL have port keep_ds_i  input  1  with flush_i, retain the oldest entry as the delay slot.
REQ-006 SHALL have port push_valid_i  input  1  fetch presents an instruction.
REQ-007 SHALL have port push_pc_i  input  32  PC of the pushed instruction.
REQ-008 SHALL have port push_instr_i  input  32  pushed instruction word.
REQ-009 SHALL have port push_ready_o  output  1  queue can accept a push.
REQ-010 SHALL have port pop_ready_i  input  1  decode consumes the head (driven as ~id_stall).
REQ-011 SHALL have port pop_valid_o  output  1  head instruction valid.
REQ-012 SHALL have port pop_pc_o  output  32  head PC.
REQ-013 SHALL have port pop_instr_o  output  32  head instruction word to decode.
REQ-014 SHALL have port count_o  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL store entries in a circular buffer with read/write pointers that wrap modulo DEPTH.
REQ-016 SHALL accept a push only when push_valid_i && push_ready_o.
REQ-017 SHALL perform a pop only when pop_valid_o && pop_ready_i.
REQ-018 SHALL drive push_ready_o = (count_o < DEPTH), independent of pop_ready_i; a full queue rejects a push even when a pop occurs in the same cycle.
REQ-019 SHALL, on a same-cycle push and pop in a non-empty, non-full queue, leave count unchanged and advance both pointers.
REQ-020 SHALL make a pushed entry visible at the head no earlier than the following cycle (1-cycle latency) unless INST_QUEUE_BYPASS_EN applies.
REQ-021 SHALL drive pop_instr_o = 32'h0 (NOP) and pop_pc_o = 32'h0 whenever pop_valid_o = 0.
REQ-022 SHALL implement states EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH), derived from count.
REQ-023 SHALL make the state transitions follow net push minus pop per cycle.
REQ-024 SHALL, on flush_i=1 with keep_ds_i=0, go to EMPTY next cycle and ignore same-cycle push and pop.
REQ-025 SHALL, on flush_i=1 with keep_ds_i=1 and count≥1, retain only the current head entry (count=1 next cycle).
REQ-026 SHALL not count a same-cycle pop of that head; the retained head is re-presented.
REQ-027 SHALL, on flush_i=1 with keep_ds_i=1 and count=0, accept a same-cycle push as the sole retained entry.
REQ-028 SHALL, in the REQ-027 case with no push, go to EMPTY.
REQ-029 SHALL give flush_i priority over push and pop in every state.
REQ-030 SHALL never overflow or underflow count_o.

Reset
REQ-031 SHALL, while rst=1, asynchronously clear both pointers, count_o=0, pop_valid_o=0, pop_pc_o=0, pop_instr_o=0.
REQ-032 SHALL drive push_ready_o=1 during reset.
REQ-033 SHALL make a reset asserted mid-operation discard all entries.
REQ-034 SHALL make the first push after rst deasserts appear at the head one cycle later.
REQ-035 SHALL leave storage array contents undefined after reset; they are never observable.

Configuration
REQ-036 SHALL, with macro INST_QUEUE_BYPASS_EN defined, combinationally forward push inputs to the head outputs when count=0, push_valid_i=1 and flush_i=0.
REQ-037 SHALL, in that bypass case, not write the entry when pop_ready_i=1 (zero-cycle latency); when pop_ready_i=0 the entry is written normally.
REQ-038 SHALL, without INST_QUEUE_BYPASS_EN, keep pop_valid_o strictly registered, giving 1-cycle minimum latency.

Verification
REQ-039 SHALL cover: push PCs 0xBFC00000..0xBFC0000C with pop_ready_i=0 -> count_o=4, push_ready_o=0; 5th push rejected.
REQ-040 SHALL cover: full queue, push_valid_i=1 and pop_ready_i=1 -> pop of 0xBFC00000 occurs, push rejected, count_o=3.
REQ-041 SHALL cover: continuous push/pop of 10 instructions -> FIFO order preserved across pointer wrap, instr words match.
REQ-042 SHALL cover: count=3, flush_i=1, keep_ds_i=1, pop_ready_i=1 -> next cycle count_o=1, head PC unchanged.
REQ-043 SHALL cover: count=2, flush_i=1, keep_ds_i=0, push_valid_i=1 -> next cycle count_o=0, pop_instr_o=0.
REQ-044 SHALL cover: rst pulsed with count=3 -> outputs zero immediately; with INST_QUEUE_BYPASS_EN, first push of 0x24020001 shows pop_valid_o=1 the same cycle.
